fir_filter_2d_pm: RTL and testbench

3×3 2-D FIR (convolution) engine for 24-bit RGB images, ten pixels processed in parallel. Sits behind the DMA controller: it first receives nine signed per-channel tap coefficients, then streams nine-beat groups where beat k carries the k-th neighbourhood pixel of ten target pixels. After each group it emits ten filtered, saturated RGB pixels in one 240-bit word.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_lane_mac.sv | 23 ++
 rtl/fir_filter_2d_pm.sv | 63 ++++++
 tb/tb_fir_filter_2d_pm.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and the accumulator-to-byte clamp for the 3x3 RGB FIR
package fir_pkg;
  localparam int LANES = 10;
  localparam int TAPS  = 9;
  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int ACC_W = 20;
  localparam int NCH   = PIX_W / CH_W;

  function automatic logic [CH_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1] ? '0 : (|a[ACC_W-2:CH_W]) ? '1 : a[CH_W-1:0];
  endfunction
endpackage

// File: rtl/fir_lane_mac.sv
// fir_lane_mac: one pixel lane, three signed per-channel MACs with clamped RGB result
module fir_lane_mac
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] coef,
  output logic [PIX_W-1:0] res
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [ACC_W-1:0] acc, prod;
    assign prod = $signed({{(ACC_W-CH_W){1'b0}}, pix[c*CH_W +: CH_W]}) *
                  $signed({{(ACC_W-CH_W){coef[c*CH_W+CH_W-1]}}, coef[c*CH_W +: CH_W]});
    // First beat of a group overwrites, later beats accumulate
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (en) acc <= clr ? prod : acc + prod;
    assign res[c*CH_W +: CH_W] = clamp_u8(acc);
  end
endmodule

// File: rtl/fir_filter_2d_pm.sv
// fir_filter_2d_pm: 3x3 RGB convolution over ten parallel lanes fed by nine-beat groups
module fir_filter_2d_pm
  import fir_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*PIX_W-1:0] input_data,
  input  logic                   valid_dmac,
  input  logic                   tc_set,
  output logic [LANES*PIX_W-1:0] output_data,
  output logic                   valid_core
);
  logic [PIX_W-1:0] coef [TAPS];
  logic [3:0] tc_cnt, beat_cnt;
  logic done, data_beat, coef_beat;
  logic [PIX_W-1:0] tap_c;
  logic [LANES*PIX_W-1:0] res;

  assign data_beat = valid_dmac & ~tc_set;
  assign coef_beat = valid_dmac & tc_set;
  assign tap_c     = coef[beat_cnt];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fir_lane_mac u_mac (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (data_beat),
      .clr  (beat_cnt == 4'd0),
      .pix  (input_data[LANES*PIX_W-1-PIX_W*l -: PIX_W]),
      .coef (tap_c),
      .res  (res[LANES*PIX_W-1-PIX_W*l -: PIX_W])
    );
  end

  // Coefficient bank, loaded sequentially and kept until overwritten
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    else if (coef_beat) coef[tc_cnt] <= input_data[PIX_W-1:0];

  // Tap and beat counters; a coefficient beat abandons any partial group
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tc_cnt   <= '0;
      beat_cnt <= '0;
    end else if (coef_beat) begin
      tc_cnt   <= (tc_cnt == 4'(TAPS-1)) ? 4'd0 : tc_cnt + 4'd1;
      beat_cnt <= '0;
    end else if (data_beat) begin
      beat_cnt <= (beat_cnt == 4'(TAPS-1)) ? 4'd0 : beat_cnt + 4'd1;
    end

  // Publish the clamped accumulators the cycle after the last beat lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done        <= 1'b0;
      valid_core  <= 1'b0;
      output_data <= '0;
    end else begin
      done        <= data_beat && beat_cnt == 4'(TAPS-1);
      valid_core  <= done;
      output_data <= done ? res : output_data;
    end
endmodule

// File: tb/tb_fir_filter_2d_pm.sv
// tb_fir_filter_2d_pm: scoreboard bench for the 3x3 ten-lane RGB FIR
module tb_fir_filter_2d_pm;
  logic clk = 1'b0;
  logic rst_n;
  logic [239:0] input_data;
  logic valid_dmac, tc_set;
  logic [239:0] output_data;
  logic valid_core;

  int tests = 0, fails = 0, cyc = 0, pulses = 0, last_beat_cyc = 0;
  logic [23:0] tb_coef [9];
  logic [23:0] grp [9][10];
  logic [239:0] exp_q [$];

  fir_filter_2d_pm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_data (input_data),
    .valid_dmac (valid_dmac),
    .tc_set     (tc_set),
    .output_data(output_data),
    .valid_core (valid_core)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid_core === 1'b1) pulses++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [239:0] rand240();
    logic [239:0] r;
    for (int i = 0; i < 10; i++) r[i*24 +: 24] = 24'($urandom);
    return r;
  endfunction

  // Reference: integer convolution with signed taps and explicit clamp
  function automatic logic [239:0] model();
    logic [239:0] r = '0;
    for (int l = 0; l < 10; l++)
      for (int ch = 0; ch < 3; ch++) begin
        int s = 0;
        for (int k = 0; k < 9; k++) begin
          logic signed [7:0] c = tb_coef[k][ch*8 +: 8];
          logic [7:0] p = grp[k][l][ch*8 +: 8];
          s += int'(p) * int'(c);
        end
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        r[216-24*l + ch*8 +: 8] = 8'(s);
      end
    return r;
  endfunction

  task automatic beat(input logic [239:0] d, input logic tc);
    input_data = d;
    tc_set = tc;
    valid_dmac = 1'b1;
    @(posedge clk); #1;
    valid_dmac = 1'b0;
    tc_set = $urandom_range(0, 1) == 1;
    input_data = rand240();
  endtask

  task automatic load_coefs();
    for (int k = 0; k < 9; k++) begin
      logic [239:0] d = rand240();
      d[23:0] = tb_coef[k];
      beat(d, 1'b1);
    end
  endtask

  task automatic send_group(input int nbeats, input int stall_at, input int stall_len);
    if (nbeats == 9) exp_q.push_back(model());
    for (int k = 0; k < nbeats; k++) begin
      logic [239:0] d;
      if (k == stall_at)
        repeat (stall_len) begin
          @(posedge clk); #1;
          tests++;
          if (valid_core !== 1'b0) begin
            fails++;
            $display("FAIL stall_early_valid: valid_core=%b want 0", valid_core);
          end
        end
      for (int l = 0; l < 10; l++) d[216-24*l +: 24] = grp[k][l];
      beat(d, 1'b0);
    end
    last_beat_cyc = cyc;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int oc);
    got = 1'b0;
    oc = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (valid_core === 1'b1) begin
        got = 1'b1;
        oc = cyc;
        break;
      end
    end
  endtask

  task automatic rand_grp();
    for (int k = 0; k < 9; k++) for (int l = 0; l < 10; l++) grp[k][l] = 24'($urandom);
  endtask

  task automatic set_identity();
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'h0;
    tb_coef[4] = 24'h010101;
  endtask

  task automatic test_reset();
    bit got; int oc; logic [239:0] e;
    rst_n = 1'b0; valid_dmac = 1'b0; tc_set = 1'b0; input_data = '0;
    repeat (3) @(posedge clk); #1;
    tests++;
    if (output_data !== '0) begin fails++; $display("FAIL reset_out: got %h want 0", output_data); end
    tests++;
    if (valid_core !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_core); end
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'h0;
    rand_grp();
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL reset_zero_coefs: got %h want %h", output_data, e); end
  endtask

  task automatic test_identity();
    bit got; int oc; logic [239:0] e;
    set_identity();
    load_coefs();
    rand_grp();
    for (int l = 0; l < 10; l++) grp[4][l] = 24'h102030 + 24'(l);
    send_group(9, -1, 0);
    tests++;
    if (valid_core !== 1'b0) begin fails++; $display("FAIL identity_early: valid_core=%b want 0", valid_core); end
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL identity: got %h want %h", output_data, e); end
    tests++;
    if (oc - last_beat_cyc != 1) begin fails++; $display("FAIL identity_latency: got %0d want 1", oc - last_beat_cyc); end
    @(posedge clk); #1;
    tests++;
    if (valid_core !== 1'b0) begin fails++; $display("FAIL identity_pulse: valid_core=%b want 0", valid_core); end
    tests++;
    if (output_data !== e) begin fails++; $display("FAIL identity_hold: got %h want %h", output_data, e); end
  endtask

  task automatic test_emboss();
    bit got; int oc; logic [239:0] e;
    tb_coef = '{24'h020202, 24'h010101, 24'h0, 24'h010101, 24'h0,
                24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'hFEFEFE};
    load_coefs();
    for (int k = 0; k < 9; k++) for (int l = 0; l < 10; l++) grp[k][l] = 24'h808080;
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL emboss_flat: got %h want %h", output_data, e); end
    for (int k = 0; k < 9; k++) for (int l = 0; l < 10; l++) grp[k][l] = (k == 0) ? 24'h404040 : 24'h0;
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL emboss_corner: got %h want %h", output_data, e); end
  endtask

  task automatic test_saturation();
    bit got; int oc; logic [239:0] e;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'h7F7F7F;
    load_coefs();
    for (int k = 0; k < 9; k++) for (int l = 0; l < 10; l++) grp[k][l] = 24'hFFFFFF;
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL sat_high: got %h want %h", output_data, e); end
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'h0;
    tb_coef[0] = 24'hFFFFFF;
    load_coefs();
    rand_grp();
    for (int l = 0; l < 10; l++) grp[0][l] = 24'h101010;
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL sat_low: got %h want %h", output_data, e); end
  endtask

  task automatic test_random();
    bit got; int oc; logic [239:0] e;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
      load_coefs();
      rand_grp();
      send_group(9, -1, 0);
      wait_valid(5, got, oc);
      e = exp_q.pop_front();
      tests++;
      if (!got || output_data !== e) begin fails++; $display("FAIL random_%0d: got %h want %h", t, output_data, e); end
    end
  endtask

  task automatic test_stall();
    bit got; int oc; logic [239:0] e;
    set_identity();
    load_coefs();
    rand_grp();
    for (int l = 0; l < 10; l++) grp[4][l] = 24'h102030 + 24'(l);
    send_group(9, 4, 4);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL stall: got %h want %h", output_data, e); end
    tests++;
    if (oc - last_beat_cyc != 1) begin fails++; $display("FAIL stall_latency: got %0d want 1", oc - last_beat_cyc); end
  endtask

  task automatic test_reload();
    bit got; int oc; int p0; logic [239:0] e;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
    load_coefs();
    p0 = pulses;
    rand_grp();
    send_group(5, -1, 0);
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
    load_coefs();
    rand_grp();
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL reload: got %h want %h", output_data, e); end
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (pulses - p0 != 1) begin fails++; $display("FAIL reload_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    int oc1, oc2;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
    load_coefs();
    fork
      begin
        rand_grp();
        send_group(9, -1, 0);
        rand_grp();
        send_group(9, -1, 0);
      end
      begin
        bit got; logic [239:0] e;
        wait_valid(30, got, oc1);
        e = exp_q.pop_front();
        tests++;
        if (!got || output_data !== e) begin fails++; $display("FAIL b2b_first: got %h want %h", output_data, e); end
        wait_valid(30, got, oc2);
        e = exp_q.pop_front();
        tests++;
        if (!got || output_data !== e) begin fails++; $display("FAIL b2b_second: got %h want %h", output_data, e); end
      end
    join
    tests++;
    if (oc2 - oc1 != 9) begin fails++; $display("FAIL b2b_rate: got %0d cycles want 9", oc2 - oc1); end
  endtask

  task automatic test_reset_mid();
    bit got; int oc; logic [239:0] e;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
    load_coefs();
    rand_grp();
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL pre_reset: got %h want %h", output_data, e); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (output_data !== '0 || valid_core !== 1'b0) begin
      fails++; $display("FAIL reset_async: out=%h valid=%b want 0/0", output_data, valid_core);
    end
    #1 rst_n = 1'b1;
    load_coefs();
    rand_grp();
    send_group(4, -1, 0);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'h0;
    rand_grp();
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL reset_cleared_coefs: got %h want %h", output_data, e); end
    for (int k = 0; k < 9; k++) tb_coef[k] = 24'($urandom);
    load_coefs();
    rand_grp();
    send_group(9, -1, 0);
    wait_valid(5, got, oc);
    e = exp_q.pop_front();
    tests++;
    if (!got || output_data !== e) begin fails++; $display("FAIL reset_reload: got %h want %h", output_data, e); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_emboss();
    test_saturation();
    test_random();
    test_stall();
    test_reload();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
